// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a multiplexed-display digit scanner.
// Optional BCD_SCAN_LEADING_BLANK_EN: drive 4'hF on bcd_out for leading zero digits.

module bcd_digit (
  input  logic [3:0] d_i,
  input  logic       ci_i,
  input  logic       up_i,
  output logic [3:0] nd_o,
  output logic       co_o
);
  always_comb begin
    nd_o = d_i;
    co_o = 1'b0;
    if (ci_i) begin
      if (up_i) begin
        if (d_i == 4'd9) begin
          nd_o = 4'd0;
          co_o = 1'b1;
        end else begin
          nd_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == 4'd0) begin
          nd_o = 4'd9;
          co_o = 1'b1;
        end else begin
          nd_o = d_i - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     digit_sel
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);

  logic [DIGITS-1:0][3:0] count_q, count_d, step, ld_san;
  logic [DIGITS:0]        cy;
  logic                   carry_q, carry_d;
  logic [DW-1:0]          div_q, div_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DIGITS-1:0]      sel_q, sel_d;
  logic [3:0]             bcd_q, bcd_d;

  // Ripple carry/borrow chain; en is the carry into digit 0.
  assign cy[0] = en;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .d_i  (count_q[g]),
        .ci_i (cy[g]),
        .up_i (up),
        .nd_o (step[g]),
        .co_o (cy[g+1])
      );
      assign ld_san[g] = (load_val[4*g +: 4] > 4'd9) ? 4'd0 : load_val[4*g +: 4];
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (load) begin
      count_d = ld_san;
    end else if (en) begin
      count_d = step;
      carry_d = cy[DIGITS];
    end
  end

  always_comb begin
    div_d = div_q + DW'(1);
    idx_d = idx_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < DIGITS; i++) sel_d[i] = (idx_q == IW'(i));
  end

`ifdef BCD_SCAN_LEADING_BLANK_EN
  // hz[i]: digit i and every digit above it are zero.
  logic [DIGITS-1:0] hz;
  always_comb begin
    hz[DIGITS-1] = (count_q[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) hz[i] = hz[i+1] && (count_q[i] == 4'd0);
    bcd_d = (idx_q != '0 && hz[idx_q]) ? 4'hF : count_q[idx_q];
  end
`else
  always_comb begin
    bcd_d = count_q[idx_q];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      sel_q   <= DIGITS'(1);
      bcd_q   <= 4'h0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      bcd_q   <= bcd_d;
    end
  end

  assign count     = count_q;
  assign carry     = carry_q;
  assign bcd_out   = bcd_q;
  assign digit_sel = sel_q;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed + randomized bench for bcd_scan_counter against an integer-arithmetic model.
module tb_bcd_scan_counter;
  localparam int D   = 4;
  localparam int SD  = 4;
  localparam int MOD = 10000;

  logic        clk = 1'b0;
  logic        rst_n, en, up, load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;

  int passed = 0;
  int total  = 0;

  int          m_cnt = 0;
  int          m_k   = 0;
  logic        m_carry = 1'b0;
  logic [3:0]  e_sel = 4'b0001;
  logic [3:0]  e_bout = 4'h0;

  bcd_scan_counter #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .carry(carry), .bcd_out(bcd_out), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  function automatic int pw10(input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pw10(i)) % 10);
    return r;
  endfunction

  function automatic int san(input logic [15:0] lv);
    int v = 0;
    int n;
    for (int i = 0; i < D; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 0;
      v = v + n * pw10(i);
    end
    return v;
  endfunction

  function automatic logic [3:0] digit_of(input int v, input int i);
`ifdef BCD_SCAN_LEADING_BLANK_EN
    if (i > 0 && v < pw10(i)) return 4'hF;
`endif
    return 4'((v / pw10(i)) % 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [15:0] lv);
    int idx;
    rst_n = r; en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    if (!r) begin
      m_cnt = 0; m_carry = 1'b0; m_k = 0; e_sel = 4'b0001; e_bout = 4'h0;
    end else begin
      idx     = (m_k / SD) % D;
      e_bout  = digit_of(m_cnt, idx);
      e_sel   = 4'(1 << idx);
      m_carry = 1'b0;
      if (l) m_cnt = san(lv);
      else if (e) begin
        if (u) begin
          if (m_cnt == MOD - 1) begin m_cnt = 0; m_carry = 1'b1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = MOD - 1; m_carry = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
      end
      m_k++;
    end
    #1;
    chk("count",     32'(count),     32'(to_bcd(m_cnt)));
    chk("carry",     32'(carry),     32'(m_carry));
    chk("digit_sel", 32'(digit_sel), 32'(e_sel));
    chk("bcd_out",   32'(bcd_out),   32'(e_bout));
  endtask

  initial begin
    logic [15:0] lv;
    logic        r, e, u, l;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    step(0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    // reset mid-count at 0x0042
    step(1, 0, 1, 1, 16'h0040);
    step(1, 1, 1, 0, 16'h0);
    step(1, 1, 1, 0, 16'h0);
    repeat (3) step(0, 1, 1, 0, 16'h0);
    step(1, 0, 1, 0, 16'h0);
    // increment wrap
    step(1, 0, 1, 1, 16'h9998);
    step(1, 1, 1, 0, 16'h0);
    step(1, 1, 1, 0, 16'h0);
    step(1, 0, 1, 0, 16'h0);
    // borrow chain and decrement wrap
    step(1, 0, 1, 1, 16'h1000);
    step(1, 1, 0, 0, 16'h0);
    step(1, 0, 1, 1, 16'h0000);
    step(1, 1, 0, 0, 16'h0);
    // load priority over en, nibble sanitising
    step(1, 1, 1, 1, 16'h12A4);
    step(1, 1, 1, 1, 16'hFFFF);
    // scan a full frame and a bit more at 0x1234, then leading-zero patterns
    step(1, 0, 1, 1, 16'h1234);
    repeat (20) step(1, 0, 1, 0, 16'h0);
    step(1, 0, 1, 1, 16'h0070);
    repeat (18) step(1, 0, 1, 0, 16'h0);
    step(1, 0, 1, 1, 16'h0000);
    repeat (18) step(1, 0, 1, 0, 16'h0);
    // continuous counting across wrap, both directions
    step(1, 0, 1, 1, 16'h9995);
    repeat (10) step(1, 1, 1, 0, 16'h0);
    repeat (12) step(1, 1, 0, 0, 16'h0);
    // randomized traffic
    repeat (600) begin
      r = ($urandom_range(0, 49) != 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'h9990;
        3: lv = 16'h0005;
        default: lv = 16'($urandom);
      endcase
      step(r, e, u, l, lv);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Multi-digit BCD up/down counter with built-in digit scanning for a multiplexed 7-segment display. It holds a DIGITS-wide packed BCD count and presents one digit at a time on a 4-bit BCD bus, together with a one-hot digit select. The BCD bus feeds the combinational BCD-to-7-segment decoder directly: bit 3 drives A (MSB), bit 0 drives D. The decoder's segment outputs plus `digit_sel` drive the display.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected; legal range ≥2.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `en`, input, 1: count enable; one step per cycle while high.
- `up`, input, 1: direction; 1 = increment, 0 = decrement. Sampled with `en`.
- `load`, input, 1: synchronous parallel load of `load_val`.
- `load_val`, input, 4*DIGITS: packed BCD value; digit 0 is at [3:0].
- `count`, output, 4*DIGITS: current packed BCD count, registered.
- `carry`, output, 1: one-cycle pulse on wrap in either direction.
- `bcd_out`, output, 4: BCD code of the currently scanned digit, registered; [3] = A … [0] = D.
- `digit_sel`, output, DIGITS: one-hot, active-high select of the scanned digit.

## Operation

- Counter, with priority `rst_n` low > `load` > `en`:
  - `load`: `count` ← `load_val`. Any nibble > 9 is loaded as 0. `carry` stays 0.
  - `en` with `up` = 1: BCD increment. A digit going 9→0 carries into the next digit.
  - `en` with `up` = 0: BCD decrement. A digit going 0→9 borrows from the next digit.
  - Wrap up: all-9s → all-0s with `carry` = 1. Wrap down: all-0s → all-9s with `carry` = 1.
  - Neither `load` nor `en`: hold, `carry` = 0.
- Scanner:
  - Divider `div` counts 0..SCAN_DIV-1 and is free-running, independent of `en` and `load`.
  - When `div` = SCAN_DIV-1, `div` → 0 and digit index `idx` → (idx+1) mod DIGITS.
  - Every cycle, `digit_sel` ← one-hot(idx) and `bcd_out` ← digit idx of the updated count.
- `digit_sel` is exactly one-hot at all times, including during and immediately after reset.
- Reset (any cycle, including mid-scan or mid-count): `count` = 0, `carry` = 0, `div` = 0, `idx` = 0, `digit_sel` = 1 (digit 0), `bcd_out` = 4'h0.

## Timing

- Count latency: `load` or `en` sampled at edge N appears on `count` after edge N.
- `carry` is asserted for the same cycle that the wrapped value first appears on `count`.
- Display latency: `bcd_out` reflects the new count after edge N+1, i.e. one cycle after `count`.
- Scan period: each digit is selected for exactly SCAN_DIV cycles. The full frame is DIGITS×SCAN_DIV cycles.
- `digit_sel` and `bcd_out` change on the same edge, so there is no cycle in which the select and the data are mismatched.
- Continuous `en` steps the count once per cycle with no gaps.

## Configuration

- Macro: `BCD_SCAN_LEADING_BLANK_EN`.
- Defined: the scanned digit outputs `bcd_out` = 4'hF when its value is 0 and every more-significant digit is also 0. The decoder maps 4'hF to all segments off, so leading zeros are blanked. Digit 0 is never blanked, so count 0 shows a single "0". `digit_sel` behaviour is unchanged.
- Undefined: `bcd_out` always carries the true digit value, so leading zeros are displayed.

## Test plan

- Reset: hold `rst_n` = 0 for 3 cycles mid-count at 0x0042 → after release, `count` = 0x0000, `digit_sel` = 4'b0001, `bcd_out` = 0, `carry` = 0.
- Load then increment: load 0x9998, then 2 cycles of `en`=1, `up`=1 → `count` goes 0x9999 then 0x0000 with `carry` = 1 only on the 0x0000 cycle.
- Borrow chain: load 0x1000, then 1 cycle of `en`=1, `up`=0 → `count` = 0x0999, `carry` = 0. Load 0x0000 and decrement → 0x9999 with `carry` = 1.
- Priority and sanitising: assert `load` (value 0x12A4) together with `en` → `count` = 0x1204 (nibble A replaced by 0), no increment, `carry` = 0.
- Scan (SCAN_DIV=4, count=0x1234): `digit_sel` steps 0001→0010→0100→1000→0001, 4 cycles each, with `bcd_out` = 4, 3, 2, 1 respectively.
- With `BCD_SCAN_LEADING_BLANK_EN` defined and count = 0x0070: `bcd_out` = 0, 7, F, F for digits 0–3. With count = 0x0000: `bcd_out` = 0, F, F, F.
